seq_multiplier_32bit: RTL and testbench
=======================================

Name: seq_multiplier_32bit

Overview:
- Multi-cycle 32x32 -> 64-bit multiplier for MIPS MULT/MULTU.
- Sits in the execute stage beside the ALU and drives the HI/LO registers.
- Uses a shift-add algorithm with one full_adder_32bit instance.
- Each RUN cycle, the block feeds that adder the partial-product upper word plus the multiplicand, and consumes its sum and carry-out.

Parameters:
- WIDTH, 32, operand width; only 32 is supported, because the adder instance is fixed at 32 bits.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE or DONE
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
- a  in  32  multiplicand; sampled with start
- b  in  32  multiplier; sampled with start
- busy  out  1  high in RUN and FIX
- done  out  1  one-cycle pulse; hi/lo valid
- hi  out  32  product bits 63:32
- lo  out  32  product bits 31:0

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Values while rst is asserted: state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, count = 0, internal product = 0.
- Internal registers:
  - mcand[31:0]
  - prod[64:0]: bit 64 is carry, 63:32 is upper, 31:0 is the multiplier and low product bits
  - neg flag
  - count[5:0]
- IDLE:
  - start = 1 at edge E0 loads mcand = |a| and prod[31:0] = |b|; clears prod[64:32] and count.
  - |x| = x when is_signed = 0 or x[31] = 0; otherwise ~x + 1 (32-bit, wraps).
  - |0x80000000| = 0x80000000 as an unsigned magnitude; this is correct by design.
  - neg = is_signed & (a[31] ^ b[31]).
  - Next state is RUN.
- RUN (edges E1..E32):
  - Adder inputs: x = prod[63:32], y = prod[0] ? mcand : 0, cin = 0.
  - Update: prod <= {1'b0, cout, z, prod[31:1]}, i.e. a right shift of the 65-bit {cout, z, prod[31:0]}.
  - Adder ovf is ignored.
  - count increments each cycle; at count == 31, next state is FIX.
- FIX (edge E33):
  - If neg, P = ~prod[63:0] + 1 (64-bit, carry propagates from bit 31 to bit 32); otherwise P = prod[63:0].
  - {hi, lo} <= P; next state is DONE.
- DONE (one cycle):
  - done = 1, busy = 0.
  - At the next edge: IDLE; or RUN if start = 1, which is accepted exactly as in IDLE.
- Latency: start sampled at E0 -> done high in the cycle after E33 (34 edges). Throughput is one product per 34 cycles.
- Output hold: hi/lo keep the last result until the next FIX. They do not change during RUN.
- start while busy: ignored, with no effect on the operation in progress. Operands are not re-sampled.
- Reset mid-operation: immediate abort, all outputs 0, no done pulse.
- Operand changes on a/b/is_signed after the start cycle have no effect.
- done and busy are never high simultaneously.

Decomposition:
- Shared package (alu_pkg), holding:
  - state encodings: IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3
  - MUL_ITER = 32
  - MUL_CNT_W = 6
- One sub-module: the existing full_adder_32bit, instanced once for the RUN-stage accumulate.
- Operand magnitude and final 64-bit negate stay as local logic in this block.

Test Plan:
1. MULTU 3 x 5, start at E0 -> done high after E33; hi = 0x00000000, lo = 0x0000000F; busy high for exactly 33 cycles.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001 (exercises the cout into prod[64:63] path).
3. MULT cases:
   - -7 x 3 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB
   - -1 x -1 -> hi = 0, lo = 1
   - 0x80000000 x 0x80000000 -> hi = 0x40000000, lo = 0
   - 0x80000000 x 1 -> hi = 0xFFFFFFFF, lo = 0x80000000
4. Start 6 x 7, pulse start with a = 9, b = 9 at RUN cycle 10 -> ignored; result hi = 0, lo = 42; single done pulse.
5. Back-to-back: start 2 x 2, then assert start (10 x 10) during the DONE cycle -> first done gives lo = 4; second done 34 edges later gives lo = 100; busy re-asserts with no IDLE gap.
6. Assert rst at RUN cycle 5 of 0x1234 x 0x5678 -> busy, done, hi, lo all 0 immediately (asynchronously); after release, a fresh 4 x 4 gives lo = 16.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the execute-stage arithmetic blocks.
//   - Sequential multiplier FSM state encodings
//   - Multiplier iteration count and counter width
// ----------------------------------------------------------------------------
package alu_pkg;

    // Multiplier FSM states, kept as plain 2-bit constants so the encoding
    // stays fixed and easy to match against older netlists.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // One shift-add step per multiplier bit.
    localparam int MUL_ITER  = 32;
    localparam int MUL_CNT_W = 6;

endpackage

// File: rtl/full_adder_32bit.sv
// ----------------------------------------------------------------------------
// full_adder_32bit
//   32-bit ripple-carry adder built from a chain of 1-bit full adders.
//   Ports:
//     x, y  in  32  addends
//     cin   in  1   carry in to bit 0
//     z     out 32  sum
//     cout  out 1   carry out of bit 31
//     ovf   out 1   signed (two's complement) overflow
// ----------------------------------------------------------------------------
module full_adder_32bit (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] z,
    output logic        cout,
    output logic        ovf
);

    // w_c[i] is the carry into bit i; w_c[32] is the final carry out.
    logic [32:0] w_c;

    assign w_c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 32; i++) begin : g_bit
            assign z[i]     = x[i] ^ y[i] ^ w_c[i];
            assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
        end
    endgenerate

    assign cout = w_c[32];

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf  = w_c[32] ^ w_c[31];

endmodule

// File: rtl/seq_multiplier_32bit.sv
// ----------------------------------------------------------------------------
// seq_multiplier_32bit
//   Multi-cycle 32x32 -> 64-bit shift-add multiplier for MIPS MULT/MULTU.
//   Operates on magnitudes and applies the sign in a final fix-up cycle.
//   start at edge E0 -> done high in the cycle after E33.
//   Ports:
//     clk        in  1   rising-edge clock
//     rst        in  1   asynchronous active-high reset
//     start      in  1   request, accepted in IDLE or DONE
//     is_signed  in  1   1 = MULT, 0 = MULTU (sampled with start)
//     a          in  32  multiplicand (sampled with start)
//     b          in  32  multiplier (sampled with start)
//     busy       out 1   high in RUN and FIX
//     done       out 1   one-cycle pulse, hi/lo valid
//     hi         out 32  product[63:32]
//     lo         out 32  product[31:0]
// ----------------------------------------------------------------------------
module seq_multiplier_32bit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]           r_state;
    logic [31:0]          r_mcand;
    logic [64:0]          r_prod;
    logic                 r_neg;
    logic [MUL_CNT_W-1:0] r_count;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_neg;
    logic [31:0] w_add_y;
    logic [31:0] w_add_z;
    logic        w_add_cout;
    logic        w_add_ovf;
    logic [63:0] w_fix;
    logic        w_accept;
    logic        w_last;

    // Magnitudes of the operands. 0x80000000 negates to itself, which is the
    // correct unsigned magnitude 2^31.
    assign w_abs_a = (is_signed && a[31]) ? (~a + 32'd1) : a;
    assign w_abs_b = (is_signed && b[31]) ? (~b + 32'd1) : b;
    assign w_neg   = is_signed & (a[31] ^ b[31]);

    // A request is only seen when no operation is in flight.
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_count == MUL_CNT_W'(MUL_ITER - 1));

    // Add the multiplicand into the upper word when the current multiplier
    // bit (always at prod[0] after the previous shifts) is set.
    assign w_add_y = r_prod[0] ? r_mcand : 32'd0;

    full_adder_32bit u_add (
        .x    (r_prod[63:32]),
        .y    (w_add_y),
        .cin  (1'b0),
        .z    (w_add_z),
        .cout (w_add_cout),
        .ovf  (w_add_ovf)
    );

    // Sign fix-up across the full 64 bits.
    assign w_fix = r_neg ? (~r_prod[63:0] + 64'd1) : r_prod[63:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_mcand <= '0;
            r_prod  <= '0;
            r_neg   <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_mcand <= w_abs_a;
                        r_prod  <= {33'd0, w_abs_b};
                        r_neg   <= w_neg;
                        r_count <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    // Right shift of {cout, sum, low word}; bit 64 refills 0.
                    r_prod  <= {1'b0, w_add_cout, w_add_z, r_prod[31:1]};
                    r_count <= r_count + MUL_CNT_W'(1);
                    if (w_last) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_hi    <= w_fix[63:32];
                    r_lo    <= w_fix[31:0];
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN) || (r_state == FIX);
    assign done = (r_state == DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Adder overflow and the carry slot of prod are not needed downstream.
    logic w_unused;
    assign w_unused = &{1'b0, w_add_ovf, r_prod[64]};

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
module tb_seq_multiplier_32bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int bcnt = 0;
    logic [63:0] q[$];

    always #5 clk = ~clk;

    seq_multiplier_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Call shortly after a posedge; the following posedge is the sampling edge.
    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic push, input logic [63:0] exp);
        start = 1'b1;
        is_signed = s;
        a = x;
        b = y;
        if (push) q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        is_signed = ~s;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done();
        int c0;
        int n;
        c0 = done_cnt;
        n = 0;
        while (done_cnt == c0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (done_cnt == c0) begin
            bad++;
            $display("FAIL wait_done: timeout after %0d cycles, required a done pulse", n);
        end
    endtask

    // Monitor: pops expected results whenever done is presented.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                bcnt = 0;
            end else begin
                if (done && busy) begin
                    total++;
                    bad++;
                    $display("FAIL busy_done_overlap: busy=%b done=%b required not both", busy, done);
                end
                if (busy) bcnt++;
                if (done) begin
                    done_cnt++;
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done with %h, required no pulse", {hi, lo});
                    end else begin
                        e = q.pop_front();
                        chk("product", {hi, lo}, e);
                        chk("busy_len", 64'(bcnt), 64'd33);
                    end
                    bcnt = 0;
                end
            end
        end
    end

    initial begin
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Unsigned
        issue(1'b0, 32'd3, 32'd5, 1'b1, 64'h00000000_0000000F);
        wait_done();
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE_00000001);
        wait_done();

        // Signed
        issue(1'b1, 32'hFFFFFFF9, 32'd3, 1'b1, 64'hFFFFFFFF_FFFFFFEB);
        wait_done();
        issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001);
        wait_done();
        issue(1'b1, 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
        wait_done();
        issue(1'b1, 32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF_80000000);
        wait_done();

        // start while busy is ignored; hi/lo hold during RUN
        issue(1'b0, 32'd6, 32'd7, 1'b1, 64'd42);
        repeat (9) @(posedge clk);
        #1;
        chk("hold_during_run", {hi, lo}, 64'hFFFFFFFF_80000000);
        start = 1'b1;
        a = 32'd9;
        b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // Back-to-back: second start during the DONE cycle
        issue(1'b0, 32'd2, 32'd2, 1'b1, 64'd4);
        begin
            int n;
            n = 0;
            while (!done && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_done_seen", {63'd0, done}, 64'd1);
        end
        issue(1'b0, 32'd10, 32'd10, 1'b1, 64'd100);
        chk("b2b_busy_no_gap", {63'd0, busy}, 64'd1);
        wait_done();

        // Asynchronous reset mid-operation
        issue(1'b0, 32'h1234, 32'h5678, 1'b0, 64'd0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b0, 32'd4, 32'd4, 1'b1, 64'd16);
        wait_done();

        repeat (3) @(posedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
